// File: rtl/mlaccel_seq_pkg.sv
// Shared types and constants for the ML accelerator command sequencer:
// FSM state encoding, sequencer opcodes and command word field positions.
package mlaccel_seq_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_LOOP  = 2'd2,
      ST_SYNC  = 2'd3
   } seq_state_t;

   localparam logic [5:0] OP_CALL = 6'h03;
   localparam logic [5:0] OP_LOOP = 6'h3E;
   localparam logic [5:0] OP_SYNC = 6'h3F;

   localparam int OPC_LSB  = 0;
   localparam int OPC_MSB  = 5;
   localparam int ADDR_LSB = 6;
   localparam int ADDR_MSB = 16;
   localparam int CNT_LSB  = 17;
   localparam int CNT_MSB  = 31;

   // Code-memory call word emitted for one LOOP iteration.
   function automatic logic [WORD_W-1:0] call_word(input logic [10:0] addr,
                                                   input logic [5:0]  op);
      return {15'b0, addr, op};
   endfunction

endpackage

// File: rtl/mlaccel_seq_if.sv
// Host command push and compute-unit command handshake bundle.
// master = sequencer side, slave = host / compute unit side.
interface mlaccel_seq_if;
   import mlaccel_seq_pkg::*;

   logic              host_valid;
   logic              host_ready;
   logic [WORD_W-1:0] host_data;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [WORD_W-1:0] cmd_data;
   logic              compute_busy;

   modport master (
      input  host_valid, host_data, cmd_ready, compute_busy,
      output host_ready, cmd_valid, cmd_data
   );

   modport slave (
      output host_valid, host_data, cmd_ready, compute_busy,
      input  host_ready, cmd_valid, cmd_data
   );

endinterface

// File: rtl/mlaccel_seq_fifo.sv
// Synchronous FIFO with occupancy output; registered read pointer, no fall-through.
// A push while full is accepted only when a pop happens in the same cycle.
module mlaccel_seq_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            level <= level + (AW+1)'(1);
         else if (do_pop && !do_push)
            level <= level - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/mlaccel_sequencer.sv
// Command sequencer: buffers host words and forwards them to the compute unit,
// expanding LOOP into code-memory calls and stalling on SYNC until the pipe drains.
// Optional MLACCEL_SEQ_STATS_EN adds stat_issued, a count of cmd handshakes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing presented; pop and decode head word when available
// ST_ISSUE | forwarding a host word, waiting for cmd acceptance
// ST_LOOP  | presenting call words base+k, loop_rem calls left incl. current
// ST_SYNC  | cmd_valid low until compute_busy low two cycles in a row
module mlaccel_sequencer #(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [5:0] OP_LOOP    = mlaccel_seq_pkg::OP_LOOP,
   parameter logic [5:0] OP_SYNC    = mlaccel_seq_pkg::OP_SYNC,
   parameter logic [5:0] OP_CALL    = mlaccel_seq_pkg::OP_CALL
) (
   input  logic                        clock,
   input  logic                        resetn,
   mlaccel_seq_if.master               bus,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef MLACCEL_SEQ_STATS_EN
   ,
   output logic [31:0]                 stat_issued
`endif
);
   import mlaccel_seq_pkg::*;

   seq_state_t        state;
   logic [WORD_W-1:0] head;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              accept;
   logic              loop_last;
   logic [10:0]       loop_addr;
   logic [14:0]       loop_rem;
   logic              sync_tmr;
   logic [5:0]        head_op;
   logic [10:0]       head_base;
   logic [14:0]       head_cnt;

   assign head_op   = head[OPC_MSB:OPC_LSB];
   assign head_base = head[ADDR_MSB:ADDR_LSB];
   assign head_cnt  = head[CNT_MSB:CNT_LSB];

   assign bus.host_ready = resetn && !full;
   assign push           = bus.host_valid && bus.host_ready;
   assign accept         = bus.cmd_valid && bus.cmd_ready;
   assign loop_last      = (loop_rem == 15'd1);
   assign busy           = !empty || (state != ST_IDLE) || bus.cmd_valid;

   mlaccel_seq_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .wdata  (bus.host_data),
      .rdata  (head),
      .empty  (empty),
      .full   (full),
      .level  (fifo_level)
   );

   // Pop only when the slot it feeds is free, so ISSUE/LOOP chain with no bubble.
   always_comb begin
      pop = 1'b0;
      case (state)
         ST_IDLE:  pop = !empty;
         ST_ISSUE: pop = accept && !empty;
         ST_LOOP:  pop = accept && loop_last && !empty;
         default:  pop = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         bus.cmd_valid <= 1'b0;
         bus.cmd_data  <= '0;
         loop_addr     <= '0;
         loop_rem      <= '0;
         sync_tmr      <= 1'b0;
      end else if (pop) begin
         if (head_op == OP_SYNC) begin
            state         <= ST_SYNC;
            bus.cmd_valid <= 1'b0;
            sync_tmr      <= 1'b1;
         end else if (head_op == OP_LOOP) begin
            if (head_cnt != '0) begin
               state         <= ST_LOOP;
               bus.cmd_valid <= 1'b1;
               bus.cmd_data  <= call_word(head_base, OP_CALL);
               loop_addr     <= head_base;
               loop_rem      <= head_cnt;
            end else begin
               state         <= ST_IDLE;
               bus.cmd_valid <= 1'b0;
            end
         end else begin
            state         <= ST_ISSUE;
            bus.cmd_valid <= 1'b1;
            bus.cmd_data  <= head;
         end
      end else begin
         case (state)
            ST_ISSUE: begin
               if (accept) begin
                  state         <= ST_IDLE;
                  bus.cmd_valid <= 1'b0;
               end
            end
            ST_LOOP: begin
               if (accept) begin
                  if (loop_last) begin
                     state         <= ST_IDLE;
                     bus.cmd_valid <= 1'b0;
                  end else begin
                     loop_rem     <= loop_rem - 15'd1;
                     loop_addr    <= loop_addr + 11'd1;
                     bus.cmd_data <= call_word(loop_addr + 11'd1, OP_CALL);
                  end
               end
            end
            ST_SYNC: begin
               // Busy re-arms the two-cycle quiet window.
               if (bus.compute_busy)
                  sync_tmr <= 1'b1;
               else if (sync_tmr == 1'b0)
                  state <= ST_IDLE;
               else
                  sync_tmr <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef MLACCEL_SEQ_STATS_EN
   always_ff @(posedge clock) begin
      if (!resetn)
         stat_issued <= '0;
      else if (accept)
         stat_issued <= stat_issued + 32'd1;
   end
`endif

endmodule

// File: doc/mlaccel_sequencer.md
Name: mlaccel_sequencer

Overview:
Command initiator for the compute unit's cmd_valid/cmd_ready/cmd_data interface. It buffers host command words in a FIFO and forwards them to the compute unit. Two sequencer-local opcodes are decoded in place:
- LOOP expands into a run of code-memory calls.
- SYNC stalls issue until the compute pipeline drains.
The block sits between the host register/bus interface and the compute unit.

Parameters:
FIFO_DEPTH, 16, host command FIFO entries; power of two, minimum 2
OP_LOOP, 6'h3E, opcode of the LOOP sequencer command
OP_SYNC, 6'h3F, opcode of the SYNC sequencer command
OP_CALL, 6'h03, opcode emitted for each LOOP iteration (code-memory call)

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  synchronous active-low reset
host_valid  in  1  host command word valid
host_ready  out  1  FIFO can accept a word
host_data  in  32  host command word
cmd_valid  out  1  command to compute unit valid
cmd_ready  in  1  compute unit accepts the command
cmd_data  out  32  command word to compute unit
compute_busy  in  1  compute unit pipeline busy
busy  out  1  sequencer busy: FIFO non-empty, state not IDLE, or cmd_valid high
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: resetn is sampled on the clock edge, low = reset. During reset:
  - state = IDLE; FIFO emptied.
  - cmd_valid=0, cmd_data=0, busy=0, fifo_level=0.
  - host_ready=0 while resetn is low, then 1 from the first cycle after release.
  - Reset mid-LOOP or mid-SYNC aborts the operation; the held command is dropped.
- Host side:
  - Push when host_valid && host_ready. host_ready = !full.
  - Push and pop in the same cycle are both performed when full, so level is unchanged. Push into an empty FIFO is visible to pop on the next cycle; no fall-through.
- cmd side (compute unit keeps cmd_ready tied high, but handshake is honoured fully):
  - cmd_valid and cmd_data are registered.
  - Once cmd_valid is high, cmd_data holds stable until the cycle in which cmd_valid && cmd_ready.
  - Back-to-back issue is allowed; sustained throughput is 1 word/cycle.
- State machine: IDLE, ISSUE, LOOP, SYNC.
  - IDLE with FIFO non-empty: pop the head word w and decode w[5:0].
    - OP_SYNC goes to SYNC; nothing is forwarded.
    - OP_LOOP with count = w[31:17] nonzero loads base = w[16:6], remaining = count, then goes to LOOP.
    - OP_LOOP with count 0 is discarded; stay in IDLE.
    - Any other opcode loads cmd_data = w, sets cmd_valid, and goes to ISSUE.
  - ISSUE: on acceptance, if the FIFO is non-empty, pop and decode the next word in the same cycle (no bubble). Otherwise clear cmd_valid and go to IDLE.
  - LOOP: present cmd_data = {15'b0, addr[10:0], OP_CALL}, with addr = base + k for k = 0..count-1.
    - addr wraps modulo 2048 (11-bit).
    - Advance on each acceptance; after the last acceptance, behave as in ISSUE.
    - The FIFO is not popped during LOOP.
  - SYNC: wait with cmd_valid=0 until compute_busy has been low for 2 consecutive cycles, covering the 1-cycle accept-to-busy latency of the compute unit; then go to IDLE.
    - SYNC arriving with nothing outstanding still takes 2 cycles.
- Latency: FIFO push to cmd_valid is 2 cycles in an empty, idle system.

Optional Feature:
MLACCEL_SEQ_STATS_EN
- Defined: adds output port stat_issued[31:0], counting cmd handshakes since reset. It wraps at 2^32 and is reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mlaccel_seq_pkg holds:
  - the state enum (IDLE/ISSUE/LOOP/SYNC);
  - the opcode constants OP_CALL/OP_LOOP/OP_SYNC;
  - field positions: opcode [5:0], code address [16:6], loop count [31:17].
- One sub-module: mlaccel_seq_fifo, a synchronous FIFO with level output, parameterised by width and depth.

Test Plan:
1. Push words 0x0000_000C, 0x0001_0012 with cmd_ready=1 -> cmd_data shows them in order on consecutive cycles; first cmd_valid 2 cycles after push; fifo_level returns to 0.
2. Hold cmd_ready=0 for 5 cycles with 0x1234_5678 pending -> cmd_valid stays 1 and cmd_data stays 0x1234_5678 throughout; exactly one handshake on release.
3. LOOP word with count=3, base=0x7FF (0x0007_FFFE) -> issues 0x0001_FFC3, 0x0000_0003, 0x0000_0043 (address wraps).
4. LOOP count=0, then 0x0000_000C -> only 0x0000_000C issued.
5. Issue 0x0000_000E, then SYNC, then 0x0000_000C, with compute_busy high for 8 cycles -> 0x0000_000C not presented until 2 cycles after compute_busy falls.
6. Fill the FIFO to 16 with cmd_ready=0 -> host_ready=0 and fifo_level=16; assert resetn=0 mid-LOOP -> cmd_valid=0, fifo_level=0, busy=0 next cycle.
